// File: rtl/timer_sched_ctrl_if.sv
// Configuration/handshake bundle between the register block, the counter
// control block and the timer scheduling controller.
interface timer_sched_ctrl_if;
    // Register-block write port
    logic       wr_en;
    logic       wr_timer_en;
    logic       wr_div_en;
    logic [3:0] wr_div_val;
    logic       clr_req;
    // Counter control block handshake
    logic       halt_ack;
    logic       cnt_en;
    // Active configuration and status
    logic       timer_en;
    logic       div_en;
    logic [3:0] div_val;
    logic       cnt_clr;
    logic       cfg_busy;
    logic       upd_done;
    logic       upd_forced;
    logic       wr_err;

    modport master (
        output wr_en, wr_timer_en, wr_div_en, wr_div_val, clr_req, halt_ack, cnt_en,
        input  timer_en, div_en, div_val, cnt_clr, cfg_busy, upd_done, upd_forced, wr_err
    );

    modport slave (
        input  wr_en, wr_timer_en, wr_div_en, wr_div_val, clr_req, halt_ack, cnt_en,
        output timer_en, div_en, div_val, cnt_clr, cfg_busy, upd_done, upd_forced, wr_err
    );
endinterface

// File: rtl/timer_sched_ctrl.sv
// Timer scheduling controller: holds software config writes in shadow
// registers and applies them glitch-free at a counter tick boundary, on a
// stop request, or after a bounded timeout. All outputs are registered and
// reflect the state the FSM is in during that cycle.
module timer_sched_ctrl #(
    parameter int TMO_W = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    timer_sched_ctrl_if.slave     bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PEND  = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;
    localparam logic [2:0] ST_APPLY = 3'd4;

    localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};
    localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    // Divider select must stay within the implemented divider taps.
    function automatic logic div_legal(input logic [3:0] v);
        return (v <= 4'd8);
    endfunction

    logic [2:0]       state_q,        state_d;
    logic             ret_pend_q,     ret_pend_d;     // HALT was entered with an update pending
    logic [TMO_W-1:0] tmo_q,          tmo_d;
    logic             clr_held_q,     clr_held_d;     // clear request parked during HALT
    logic             sh_timer_en_q,  sh_timer_en_d;
    logic             sh_div_en_q,    sh_div_en_d;
    logic [3:0]       sh_div_val_q,   sh_div_val_d;
    logic             timer_en_q,     timer_en_d;
    logic             div_en_q,       div_en_d;
    logic [3:0]       div_val_q,      div_val_d;
    logic             cnt_clr_q,      cnt_clr_d;
    logic             cfg_busy_q,     cfg_busy_d;
    logic             upd_done_q,     upd_done_d;
    logic             upd_forced_q,   upd_forced_d;
    logic             wr_err_q,       wr_err_d;

    logic             wr_ok_s;
    logic             forced_s;
    logic             apply_s;
    logic [TMO_W-1:0] tmo_inc_s;

    // Next-state logic: FSM, shadow capture, timeout counter and held clear.
    always_comb begin
        wr_ok_s       = bus.wr_en && !cfg_busy_q && div_legal(bus.wr_div_val);
        tmo_inc_s     = tmo_q + TMO_ONE;
        state_d       = state_q;
        ret_pend_d    = ret_pend_q;
        tmo_d         = tmo_q;
        clr_held_d    = clr_held_q;
        forced_s      = 1'b0;
        if (wr_ok_s) begin
            sh_timer_en_d = bus.wr_timer_en;
            sh_div_en_d   = bus.wr_div_en;
            sh_div_val_d  = bus.wr_div_val;
        end else begin
            sh_timer_en_d = sh_timer_en_q;
            sh_div_en_d   = sh_div_en_q;
            sh_div_val_d  = sh_div_val_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_ok_s) begin
                    state_d = ST_APPLY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (wr_ok_s) begin
                    state_d = ST_PEND;
                    tmo_d   = {TMO_W{1'b0}};
                end else if (bus.halt_ack) begin
                    state_d    = ST_HALT;
                    ret_pend_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PEND: begin
                // A stop request is never deferred to a tick boundary.
                if (!sh_timer_en_q) begin
                    state_d = ST_APPLY;
                end else if (bus.halt_ack) begin
                    state_d    = ST_HALT;
                    ret_pend_d = 1'b1;
                end else if (bus.cnt_en) begin
                    state_d = ST_APPLY;
                end else if (tmo_inc_s == TMO_MAX) begin
                    state_d  = ST_APPLY;
                    forced_s = 1'b1;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            ST_HALT: begin
                // Timeout is frozen here; a write accepted while halted from
                // RUN turns the return path into a fresh PEND.
                if (bus.halt_ack) begin
                    state_d    = ST_HALT;
                    clr_held_d = clr_held_q || bus.clr_req;
                    if (wr_ok_s) begin
                        ret_pend_d = 1'b1;
                        tmo_d      = {TMO_W{1'b0}};
                    end else begin
                        ret_pend_d = ret_pend_q;
                    end
                end else begin
                    clr_held_d = 1'b0;
                    if (wr_ok_s) begin
                        state_d = ST_PEND;
                        tmo_d   = {TMO_W{1'b0}};
                    end else if (ret_pend_q) begin
                        state_d = ST_PEND;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_APPLY: begin
                ret_pend_d = 1'b0;
                if (sh_timer_en_q) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ret_pend_d = 1'b0;
                clr_held_d = 1'b0;
            end
        endcase
    end

    // Output next-values, computed from the state being entered so that each
    // output is valid during the cycle its state occupies.
    always_comb begin
        apply_s = (state_d == ST_APPLY);
        if (apply_s) begin
            timer_en_d = sh_timer_en_d;
            div_en_d   = sh_div_en_d;
            div_val_d  = sh_div_val_d;
        end else begin
            timer_en_d = timer_en_q;
            div_en_d   = div_en_q;
            div_val_d  = div_val_q;
        end
        // Write-triggered and software clears that coincide merge into one pulse.
        cnt_clr_d    = apply_s
                     || (((state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_PEND))
                         && bus.clr_req)
                     || ((state_q == ST_HALT) && !bus.halt_ack && (clr_held_q || bus.clr_req));
        cfg_busy_d   = (state_d == ST_PEND) || apply_s
                     || ((state_d == ST_HALT) && ret_pend_d);
        upd_done_d   = apply_s;
        upd_forced_d = forced_s;
        wr_err_d     = bus.wr_en && !wr_ok_s;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ret_pend_q    <= 1'b0;
            tmo_q         <= {TMO_W{1'b0}};
            clr_held_q    <= 1'b0;
            sh_timer_en_q <= 1'b0;
            sh_div_en_q   <= 1'b0;
            sh_div_val_q  <= 4'd0;
            timer_en_q    <= 1'b0;
            div_en_q      <= 1'b0;
            div_val_q     <= 4'd0;
            cnt_clr_q     <= 1'b0;
            cfg_busy_q    <= 1'b0;
            upd_done_q    <= 1'b0;
            upd_forced_q  <= 1'b0;
            wr_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_pend_q    <= ret_pend_d;
            tmo_q         <= tmo_d;
            clr_held_q    <= clr_held_d;
            sh_timer_en_q <= sh_timer_en_d;
            sh_div_en_q   <= sh_div_en_d;
            sh_div_val_q  <= sh_div_val_d;
            timer_en_q    <= timer_en_d;
            div_en_q      <= div_en_d;
            div_val_q     <= div_val_d;
            cnt_clr_q     <= cnt_clr_d;
            cfg_busy_q    <= cfg_busy_d;
            upd_done_q    <= upd_done_d;
            upd_forced_q  <= upd_forced_d;
            wr_err_q      <= wr_err_d;
        end
    end

    assign bus.timer_en   = timer_en_q;
    assign bus.div_en     = div_en_q;
    assign bus.div_val    = div_val_q;
    assign bus.cnt_clr    = cnt_clr_q;
    assign bus.cfg_busy   = cfg_busy_q;
    assign bus.upd_done   = upd_done_q;
    assign bus.upd_forced = upd_forced_q;
    assign bus.wr_err     = wr_err_q;

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Self-checking bench for timer_sched_ctrl: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (halt, timeout, reset).
module tb_timer_sched_ctrl;

    typedef struct {
        logic [9:0]  vin;   // {wr_en, wr_timer_en, wr_div_en, wr_div_val, clr_req, halt_ack, cnt_en}
        logic [10:0] vexp;  // {timer_en, div_en, div_val, cnt_clr, cfg_busy, upd_done, upd_forced, wr_err}
    } vec_t;

    logic clk;
    logic rst;
    timer_sched_ctrl_if bus_if ();

    int          n_vec;
    int          n_err;
    string       phase;
    logic [10:0] exp_q[$];
    vec_t        tbl[$];

    timer_sched_ctrl #(.TMO_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] vi(input int we, input int t, input int d, input int v,
                                       input int c, input int h, input int ce);
        return {1'(we), 1'(t), 1'(d), 4'(v), 1'(c), 1'(h), 1'(ce)};
    endfunction

    function automatic logic [10:0] vo(input int te, input int de, input int dv, input int clr,
                                        input int busy, input int done, input int frc, input int err);
        return {1'(te), 1'(de), 4'(dv), 1'(clr), 1'(busy), 1'(done), 1'(frc), 1'(err)};
    endfunction

    task automatic drive(input logic [9:0] vin);
        {bus_if.wr_en, bus_if.wr_timer_en, bus_if.wr_div_en, bus_if.wr_div_val,
         bus_if.clr_req, bus_if.halt_ack, bus_if.cnt_en} = vin;
    endtask

    task automatic check_out();
        logic [10:0] e;
        logic [10:0] a;
        e = exp_q.pop_front();
        a = {bus_if.timer_en, bus_if.div_en, bus_if.div_val, bus_if.cnt_clr,
             bus_if.cfg_busy, bus_if.upd_done, bus_if.upd_forced, bus_if.wr_err};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s vec %0d: got %03h want %03h (te,de,dv,clr,busy,done,frc,err)",
                     phase, n_vec, a, e);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
    task automatic step(input logic [9:0] vin, input logic [10:0] vexp);
        drive(vin);
        exp_q.push_back(vexp);
        @(negedge clk);
        check_out();
    endtask

    task automatic repeat_step(input int n, input logic [9:0] vin, input logic [10:0] vexp);
        for (int k = 0; k < n; k++) begin
            step(vin, vexp);
        end
    endtask

    task automatic add(input logic [9:0] vin, input logic [10:0] vexp);
        vec_t r;
        r.vin  = vin;
        r.vexp = vexp;
        tbl.push_back(r);
    endtask

    initial begin
        logic [9:0] nop;
        clk   = 1'b0;
        rst   = 1'b1;
        n_vec = 0;
        n_err = 0;
        nop   = vi(0, 0, 0, 0, 0, 0, 0);
        drive(nop);

        // Vector table, starting from IDLE after reset.
        add(nop,                     vo(0, 0, 0, 0, 0, 0, 0, 0));
        add(vi(1, 1, 1, 3, 0, 0, 0), vo(1, 1, 3, 1, 1, 1, 0, 0)); // IDLE write -> APPLY
        add(vi(0, 0, 0, 0, 1, 0, 0), vo(1, 1, 3, 0, 0, 0, 0, 0)); // RUN; clr in APPLY absorbed
        add(vi(1, 1, 1, 9, 0, 0, 0), vo(1, 1, 3, 0, 0, 0, 0, 1)); // illegal div -> wr_err
        add(nop,                     vo(1, 1, 3, 0, 0, 0, 0, 0));
        add(vi(0, 0, 0, 0, 1, 0, 0), vo(1, 1, 3, 1, 0, 0, 0, 0)); // clr in RUN
        add(nop,                     vo(1, 1, 3, 0, 0, 0, 0, 0));
        add(vi(1, 1, 1, 5, 0, 0, 0), vo(1, 1, 3, 0, 1, 0, 0, 0)); // RUN write -> PEND
        add(vi(1, 1, 0, 7, 0, 0, 0), vo(1, 1, 3, 0, 1, 0, 0, 1)); // write while busy rejected
        add(nop,                     vo(1, 1, 3, 0, 1, 0, 0, 0));
        add(vi(0, 0, 0, 0, 0, 0, 1), vo(1, 1, 5, 1, 1, 1, 0, 0)); // tick -> APPLY
        add(nop,                     vo(1, 1, 5, 0, 0, 0, 0, 0));
        add(vi(1, 1, 1, 6, 0, 0, 0), vo(1, 1, 5, 0, 1, 0, 0, 0)); // PEND
        add(nop,                     vo(1, 1, 5, 0, 1, 0, 0, 0));
        add(vi(0, 0, 0, 0, 1, 0, 1), vo(1, 1, 6, 1, 1, 1, 0, 0)); // clr + apply coincide
        add(nop,                     vo(1, 1, 6, 0, 0, 0, 0, 0)); // single pulse only
        add(vi(1, 0, 0, 2, 0, 0, 0), vo(1, 1, 6, 0, 1, 0, 0, 0)); // stop write -> PEND
        add(nop,                     vo(0, 0, 2, 1, 1, 1, 0, 0)); // APPLY without cnt_en
        add(nop,                     vo(0, 0, 2, 0, 0, 0, 0, 0)); // IDLE
        add(vi(1, 1, 0, 4, 1, 0, 0), vo(1, 0, 4, 1, 1, 1, 0, 0)); // write + clr in IDLE
        add(nop,                     vo(1, 0, 4, 0, 0, 0, 0, 0));
        add(vi(0, 0, 0, 0, 0, 1, 0), vo(1, 0, 4, 0, 0, 0, 0, 0)); // HALT from RUN, not busy
        add(vi(0, 0, 0, 0, 1, 1, 0), vo(1, 0, 4, 0, 0, 0, 0, 0)); // clr held in HALT
        add(nop,                     vo(1, 0, 4, 1, 0, 0, 0, 0)); // held clr after exit
        add(nop,                     vo(1, 0, 4, 0, 0, 0, 0, 0));

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        phase = "reset";
        exp_q.push_back(vo(0, 0, 0, 0, 0, 0, 0, 0));
        check_out();
        rst = 1'b0;

        phase = "table";
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].vin, tbl[i].vexp);
        end

        // Halt while pending: no apply during halt even with ticks, apply on first tick after.
        phase = "halt_pend";
        step(vi(1, 1, 1, 2, 0, 0, 0), vo(1, 0, 4, 0, 1, 0, 0, 0));
        for (int k = 0; k < 20; k++) begin
            step(vi(0, 0, 0, 0, (k == 5) ? 1 : 0, 1, k % 2), vo(1, 0, 4, 0, 1, 0, 0, 0));
        end
        step(nop,                     vo(1, 0, 4, 1, 1, 0, 0, 0));
        step(vi(0, 0, 0, 0, 0, 0, 1), vo(1, 1, 2, 1, 1, 1, 0, 0));
        step(nop,                     vo(1, 1, 2, 0, 0, 0, 0, 0));

        // Forced apply after exactly 511 PEND cycles.
        phase = "timeout";
        step(vi(1, 1, 1, 4, 0, 0, 0), vo(1, 1, 2, 0, 1, 0, 0, 0));
        repeat_step(510, nop,          vo(1, 1, 2, 0, 1, 0, 0, 0));
        step(nop,                      vo(1, 1, 4, 1, 1, 1, 1, 0));
        step(nop,                      vo(1, 1, 4, 0, 0, 0, 0, 0));

        // Timeout counter frozen during HALT.
        phase = "tmo_freeze";
        step(vi(1, 1, 0, 7, 0, 0, 0), vo(1, 1, 4, 0, 1, 0, 0, 0));
        repeat_step(300, nop,                    vo(1, 1, 4, 0, 1, 0, 0, 0));
        repeat_step(20, vi(0, 0, 0, 0, 0, 1, 0), vo(1, 1, 4, 0, 1, 0, 0, 0));
        step(nop,                                vo(1, 1, 4, 0, 1, 0, 0, 0));
        repeat_step(210, nop,                    vo(1, 1, 4, 0, 1, 0, 0, 0));
        step(nop,                                vo(1, 0, 7, 1, 1, 1, 1, 0));
        step(nop,                                vo(1, 0, 7, 0, 0, 0, 0, 0));

        // Reset mid-PEND discards the update.
        phase = "rst_pend";
        step(vi(1, 1, 1, 8, 0, 0, 0), vo(1, 0, 7, 0, 1, 0, 0, 0));
        step(nop,                     vo(1, 0, 7, 0, 1, 0, 0, 0));
        rst = 1'b1;
        #1;
        exp_q.push_back(vo(0, 0, 0, 0, 0, 0, 0, 0));
        check_out();
        @(negedge clk);
        rst = 1'b0;
        repeat_step(3, vi(0, 0, 0, 0, 0, 0, 1), vo(0, 0, 0, 0, 0, 0, 0, 0));

        // Reset mid-HALT (entered from PEND) discards the update.
        phase = "rst_halt";
        step(vi(1, 1, 1, 1, 0, 0, 0), vo(1, 1, 1, 1, 1, 1, 0, 0));
        step(nop,                     vo(1, 1, 1, 0, 0, 0, 0, 0));
        step(vi(1, 1, 1, 3, 0, 0, 0), vo(1, 1, 1, 0, 1, 0, 0, 0));
        step(vi(0, 0, 0, 0, 0, 1, 0), vo(1, 1, 1, 0, 1, 0, 0, 0));
        rst = 1'b1;
        #1;
        exp_q.push_back(vo(0, 0, 0, 0, 0, 0, 0, 0));
        check_out();
        @(negedge clk);
        rst = 1'b0;
        repeat_step(3, vi(0, 0, 0, 0, 0, 0, 1), vo(0, 0, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
